// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encodings, fault word and lane order shared by
// the instruction memory loader and its byte packer.
package imem_loader_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [31:0] IMEM_ILLOP = 32'hFFFF_FFFF;

  // First byte of a word lands in bits [31:24] when set.
  localparam bit BYTE_LANE_BE = 1'b1;

  typedef struct packed {
    logic [31:0] id;
    logic        valid;
    logic        fault;
  } fetch_t;

  function automatic logic [31:0] lane_order(input logic [31:0] w);
    return BYTE_LANE_BE ? w : {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: gathers serial bytes into 32-bit words and
// zero-pads a trailing partial word on flush.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic        flush_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        done_o,
  output logic        pend_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;
  logic [31:0] word;

  always_comb begin
    cnt_d  = cnt_q;
    sr_d   = sr_q;
    word   = {sr_q, byte_i};
    done_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (flush_i) begin
      cnt_d  = '0;
      sr_d   = '0;
      done_o = cnt_q != 2'd0;
      case (cnt_q)
        2'd1:    word = {sr_q[7:0], 24'h0};
        2'd2:    word = {sr_q[15:0], 16'h0};
        default: word = {sr_q[23:0], 8'h0};
      endcase
    end else if (shift_i) begin
      cnt_d  = cnt_q + 2'd1;
      sr_d   = {sr_q[15:0], byte_i};
      done_o = cnt_q == 2'd3;
    end
  end

  assign word_o = lane_order(word);
  assign pend_o = cnt_d != 2'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writable instruction memory with registered fetch and a
// byte-serial loader FSM. IMEM_CHECKSUM_EN enables the committed-word checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH      = 128,
  parameter int          PC_W       = 32,
  parameter logic [31:0] ILLOP_WORD = IMEM_ILLOP,
  parameter string       INIT_FILE  = ""
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PC_W-1:0]        pc,
  input  logic                   fetch_en,
  output logic [31:0]            id,
  output logic                   id_valid,
  output logic                   id_fault,
  input  logic                   load_start,
  input  logic                   load_end,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic                   busy,
  output logic                   load_err,
  output logic [$clog2(DEPTH):0] words_loaded,
  output logic [31:0]            checksum
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic          err_q, err_d;
  fetch_t        fetch_q, fetch_d;
  logic          xfer, flush, full, we;
  logic          pk_done, pk_pend, pc_fault;
  logic [31:0]   pk_word;

  assign byte_ready   = state_q == ST_LOAD;
  assign busy         = state_q != ST_RUN;
  assign xfer         = byte_valid & byte_ready;
  assign flush        = state_q == ST_DRAIN;
  assign full         = wr_ptr_q == CW'(DEPTH);
  assign we           = pk_done & ~full;
  assign load_err     = err_q;
  assign words_loaded = wr_ptr_q;
  assign id           = fetch_q.id;
  assign id_valid     = fetch_q.valid;
  assign id_fault     = fetch_q.fault;

  imem_loader_byte_packer u_pack (
    .clk     (clk),
    .reset   (reset),
    .clear_i (load_start),
    .shift_i (xfer),
    .flush_i (flush),
    .byte_i  (byte_in),
    .word_o  (pk_word),
    .done_o  (pk_done),
    .pend_o  (pk_pend)
  );

  // pk_pend already accounts for a byte accepted alongside load_end.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    err_d    = err_q;
    if (load_start) begin
      state_d  = ST_LOAD;
      wr_ptr_d = '0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD:  if (load_end) state_d = pk_pend ? ST_DRAIN : ST_RUN;
        ST_DRAIN: state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
      if (pk_done) begin
        if (full) err_d = 1'b1;
        else      wr_ptr_d = wr_ptr_q + CW'(1);
      end
    end
  end

  assign pc_fault = (pc[1:0] != 2'b00) || (pc[PC_W-1:AW+2] != '0);

  always_comb begin
    fetch_d       = fetch_q;
    fetch_d.valid = 1'b0;
    fetch_d.fault = 1'b0;
    if (state_q == ST_RUN && fetch_en) begin
      fetch_d.valid = 1'b1;
      fetch_d.fault = pc_fault;
      fetch_d.id    = pc_fault ? ILLOP_WORD : mem[pc[AW+1:2]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      err_q    <= 1'b0;
      fetch_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      err_q    <= err_d;
      fetch_q  <= fetch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q[AW-1:0]] <= pk_word;
  end

`ifdef IMEM_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (load_start) sum_d = '0;
    else if (we)    sum_d = sum_q + pk_word;
  end

  always_ff @(posedge clk) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign checksum = sum_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader, one 128-word and one
// 4-word instance sharing clock and reset.
module tb_imem_loader;

`ifdef IMEM_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a_pc = '0;
  logic        a_fe = 0, a_ls = 0, a_le = 0, a_bv = 0;
  logic [7:0]  a_bi = '0;
  logic [31:0] a_id, a_ck;
  logic        a_idv, a_idf, a_br, a_busy, a_err;
  logic [7:0]  a_wl;

  logic [31:0] b_pc = '0;
  logic        b_fe = 0, b_ls = 0, b_le = 0, b_bv = 0;
  logic [7:0]  b_bi = '0;
  logic [31:0] b_id, b_ck;
  logic        b_idv, b_idf, b_br, b_busy, b_err;
  logic [2:0]  b_wl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] id;
    logic        fault;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  imem_loader u_a (
    .clk(clk), .reset(reset), .pc(a_pc), .fetch_en(a_fe),
    .id(a_id), .id_valid(a_idv), .id_fault(a_idf),
    .load_start(a_ls), .load_end(a_le), .byte_in(a_bi),
    .byte_valid(a_bv), .byte_ready(a_br), .busy(a_busy),
    .load_err(a_err), .words_loaded(a_wl), .checksum(a_ck)
  );

  imem_loader #(.DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .pc(b_pc), .fetch_en(b_fe),
    .id(b_id), .id_valid(b_idv), .id_fault(b_idf),
    .load_start(b_ls), .load_end(b_le), .byte_in(b_bi),
    .byte_valid(b_bv), .byte_ready(b_br), .busy(b_busy),
    .load_err(b_err), .words_loaded(b_wl), .checksum(b_ck)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_byte(input logic [7:0] b, input logic last);
    a_bv = 1'b1; a_bi = b; a_le = last;
    tick();
    a_bv = 1'b0; a_le = 1'b0;
  endtask

  task automatic b_byte(input logic [7:0] b, input logic last);
    b_bv = 1'b1; b_bi = b; b_le = last;
    tick();
    b_bv = 1'b0; b_le = 1'b0;
  endtask

  task automatic a_fetch(input logic [31:0] p, input logic [31:0] w, input logic f);
    exp_t e;
    e.pc = p; e.id = w; e.fault = f;
    qa.push_back(e);
    a_pc = p; a_fe = 1'b1;
    tick();
    a_fe = 1'b0;
  endtask

  task automatic b_fetch(input logic [31:0] p, input logic [31:0] w, input logic f);
    exp_t e;
    e.pc = p; e.id = w; e.fault = f;
    qb.push_back(e);
    b_pc = p; b_fe = 1'b1;
    tick();
    b_fe = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks++;
    if ({a_id, a_idv, a_idf, a_br, a_busy, a_err, a_wl, a_ck} !== '0) begin
      errors++;
      $display("FAIL reset_a id=%h v=%b f=%b rdy=%b busy=%b err=%b wl=%0d ck=%h want all 0",
               a_id, a_idv, a_idf, a_br, a_busy, a_err, a_wl, a_ck);
    end
    checks++;
    if ({b_idv, b_br, b_busy, b_err, b_wl, b_ck} !== '0) begin
      errors++;
      $display("FAIL reset_b v=%b rdy=%b busy=%b err=%b wl=%0d ck=%h want all 0",
               b_idv, b_br, b_busy, b_err, b_wl, b_ck);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] w [6];
    logic [31:0] sum;
    int          idx [3];
    exp_t        e;
    w = '{32'h0, 32'h1111_1111, 32'h2222_2222,
          32'h3333_3333, 32'h4444_4444, 32'h1234_5678};
    idx = '{5, 1, 0};
    sum = '0;
    a_ls = 1'b1; tick(); a_ls = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sum += w[i];
      for (int k = 0; k < 4; k++)
        a_byte(w[i][31-8*k -: 8], (i == 5 && k == 3));
    end
    checks++;
    if (a_busy !== 1'b0 || a_wl !== 8'd6 || a_ck !== (CK_EN ? sum : 32'd0)) begin
      errors++;
      $display("FAIL fetch_load busy=%b wl=%0d ck=%h want busy=0 wl=6 ck=%h",
               a_busy, a_wl, a_ck, CK_EN ? sum : 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      a_fetch(32'(idx[i] * 4), w[idx[i]], 1'b0);
      e = qa.pop_front();
      checks++;
      if (a_idv !== 1'b1 || a_id !== e.id || a_idf !== e.fault) begin
        errors++;
        $display("FAIL fetch pc=%0d got id=%h v=%b f=%b want id=%h v=1 f=%b",
                 e.pc, a_id, a_idv, a_idf, e.id, e.fault);
      end
    end
  endtask

  task automatic test_fault();
    logic [31:0] pcs [2];
    exp_t        e;
    pcs = '{32'd22, 32'd512};
    for (int i = 0; i < 2; i++) begin
      a_fetch(pcs[i], 32'hFFFF_FFFF, 1'b1);
      e = qa.pop_front();
      checks++;
      if (a_idv !== 1'b1 || a_id !== e.id || a_idf !== e.fault) begin
        errors++;
        $display("FAIL fault pc=%0d got id=%h v=%b f=%b want id=%h v=1 f=1",
                 e.pc, a_id, a_idv, a_idf, e.id);
      end
    end
    tick();
    checks++;
    if (a_idv !== 1'b0 || a_idf !== 1'b0 || a_id !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL idle got id=%h v=%b f=%b want id=ffffffff v=0 f=0",
               a_id, a_idv, a_idf);
    end
  endtask

  task automatic test_load();
    logic [7:0] bs [8];
    exp_t       e;
    bs = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    a_ls = 1'b1; tick(); a_ls = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_br !== 1'b1 || a_wl !== 8'd0) begin
      errors++;
      $display("FAIL load_enter busy=%b rdy=%b wl=%0d want 1 1 0", a_busy, a_br, a_wl);
    end
    a_fe = 1'b1; a_pc = '0;
    a_byte(bs[0], 1'b0);
    a_fe = 1'b0;
    checks++;
    if (a_idv !== 1'b0) begin
      errors++;
      $display("FAIL load_fetch_ignored v=%b want 0", a_idv);
    end
    for (int i = 1; i < 8; i++) a_byte(bs[i], 1'b0);
    checks++;
    if (a_busy !== 1'b1 || a_wl !== 8'd2) begin
      errors++;
      $display("FAIL load_words busy=%b wl=%0d want busy=1 wl=2", a_busy, a_wl);
    end
    a_le = 1'b1; tick(); a_le = 1'b0;
    checks++;
    if (a_busy !== 1'b0 || a_br !== 1'b0 || a_ck !== (CK_EN ? 32'hDFAF_C1F3 : 32'd0)) begin
      errors++;
      $display("FAIL load_end busy=%b rdy=%b ck=%h want busy=0 rdy=0 ck=%h",
               a_busy, a_br, a_ck, CK_EN ? 32'hDFAF_C1F3 : 32'd0);
    end
    a_fetch(32'd0, 32'hDEAD_BEEF, 1'b0);
    a_fetch(32'd4, 32'h0102_0304, 1'b0);
    for (int i = 0; i < 2; i++) begin
      e = qa.pop_front();
      checks++;
      if (e.id !== (i == 0 ? 32'hDEAD_BEEF : 32'h0102_0304)) begin
        errors++;
        $display("FAIL load_queue pc=%0d", e.pc);
      end
    end
    checks++;
    if (a_idv !== 1'b1 || a_id !== 32'h0102_0304) begin
      errors++;
      $display("FAIL load_fetch1 got id=%h v=%b want id=01020304 v=1", a_id, a_idv);
    end
  endtask

  task automatic test_drain();
    exp_t e;
    a_ls = 1'b1; tick(); a_ls = 1'b0;
    a_byte(8'hAA, 1'b0);
    a_byte(8'hBB, 1'b0);
    a_le = 1'b1; tick(); a_le = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_br !== 1'b0) begin
      errors++;
      $display("FAIL drain_state busy=%b rdy=%b want busy=1 rdy=0", a_busy, a_br);
    end
    tick();
    checks++;
    if (a_busy !== 1'b0 || a_wl !== 8'd1 || a_ck !== (CK_EN ? 32'hAABB_0000 : 32'd0)) begin
      errors++;
      $display("FAIL drain_done busy=%b wl=%0d ck=%h want busy=0 wl=1", a_busy, a_wl, a_ck);
    end
    a_fetch(32'd0, 32'hAABB_0000, 1'b0);
    e = qa.pop_front();
    checks++;
    if (a_idv !== 1'b1 || a_id !== e.id || a_idf !== e.fault) begin
      errors++;
      $display("FAIL drain_word got id=%h v=%b want id=%h v=1", a_id, a_idv, e.id);
    end
    a_fetch(32'd4, 32'h0102_0304, 1'b0);
    e = qa.pop_front();
    checks++;
    if (a_idv !== 1'b1 || a_id !== e.id) begin
      errors++;
      $display("FAIL drain_keep got id=%h want id=%h", a_id, e.id);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bs [5];
    exp_t       e;
    bs = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    a_ls = 1'b1; tick(); a_ls = 1'b0;
    for (int i = 0; i < 5; i++) a_byte(bs[i], i == 4);
    checks++;
    if (a_busy !== 1'b1 || a_br !== 1'b0 || a_wl !== 8'd1) begin
      errors++;
      $display("FAIL b2b_drain busy=%b rdy=%b wl=%0d want 1 0 1", a_busy, a_br, a_wl);
    end
    tick();
    checks++;
    if (a_busy !== 1'b0 || a_wl !== 8'd2 || a_ck !== (CK_EN ? 32'h6622_3344 : 32'd0)) begin
      errors++;
      $display("FAIL b2b_done busy=%b wl=%0d ck=%h want busy=0 wl=2", a_busy, a_wl, a_ck);
    end
    a_fetch(32'd0, 32'h1122_3344, 1'b0);
    a_fetch(32'd4, 32'h5500_0000, 1'b0);
    e = qa.pop_front();
    e = qa.pop_front();
    checks++;
    if (a_idv !== 1'b1 || a_id !== e.id) begin
      errors++;
      $display("FAIL b2b_word got id=%h want id=%h", a_id, e.id);
    end
  endtask

  task automatic test_restart();
    logic [7:0] bs [4];
    exp_t       e;
    bs = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
    a_ls = 1'b1; tick(); a_ls = 1'b0;
    a_byte(8'h77, 1'b0);
    a_byte(8'h88, 1'b0);
    a_ls = 1'b1; tick(); a_ls = 1'b0;
    for (int i = 0; i < 4; i++) a_byte(bs[i], i == 3);
    checks++;
    if (a_busy !== 1'b0 || a_wl !== 8'd1) begin
      errors++;
      $display("FAIL restart_state busy=%b wl=%0d want busy=0 wl=1", a_busy, a_wl);
    end
    a_fetch(32'd0, 32'hCAFE_BABE, 1'b0);
    e = qa.pop_front();
    checks++;
    if (a_idv !== 1'b1 || a_id !== e.id) begin
      errors++;
      $display("FAIL restart_word got id=%h want id=%h", a_id, e.id);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w [5];
    logic [31:0] sum;
    exp_t        e;
    sum = '0;
    for (int i = 0; i < 5; i++) begin
      w[i] = {8'(16 + 4*i), 8'(17 + 4*i), 8'(18 + 4*i), 8'(19 + 4*i)};
      if (i < 4) sum += w[i];
    end
    b_ls = 1'b1; tick(); b_ls = 1'b0;
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 4; k++) b_byte(w[i][31-8*k -: 8], (i == 4 && k == 3));
    checks++;
    if (b_err !== 1'b1 || b_wl !== 3'd4 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_state err=%b wl=%0d busy=%b want err=1 wl=4 busy=0",
               b_err, b_wl, b_busy);
    end
    checks++;
    if (b_ck !== (CK_EN ? sum : 32'd0)) begin
      errors++;
      $display("FAIL ovf_checksum got %h want %h", b_ck, CK_EN ? sum : 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      b_fetch(32'(4 * i), (i < 4) ? w[i] : 32'hFFFF_FFFF, i == 4);
      e = qb.pop_front();
      checks++;
      if (b_idv !== 1'b1 || b_id !== e.id || b_idf !== e.fault) begin
        errors++;
        $display("FAIL ovf_fetch pc=%0d got id=%h v=%b f=%b want id=%h v=1 f=%b",
                 e.pc, b_id, b_idv, b_idf, e.id, e.fault);
      end
    end
    b_ls = 1'b1; tick(); b_ls = 1'b0;
    checks++;
    if (b_err !== 1'b0 || b_wl !== 3'd0 || b_busy !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear err=%b wl=%0d busy=%b want err=0 wl=0 busy=1",
               b_err, b_wl, b_busy);
    end
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 4; k++) b_byte(w[i][31-8*k -: 8], 1'b0);
    checks++;
    if (b_err !== 1'b1 || b_busy !== 1'b1) begin
      errors++;
      $display("FAIL ovf_again err=%b busy=%b want err=1 busy=1", b_err, b_busy);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (b_busy !== 1'b0 || b_br !== 1'b0 || b_err !== 1'b0 || b_wl !== 3'd0) begin
      errors++;
      $display("FAIL midload_reset busy=%b rdy=%b err=%b wl=%0d want all 0",
               b_busy, b_br, b_err, b_wl);
    end
    a_fetch(32'd0, 32'hCAFE_BABE, 1'b0);
    e = qa.pop_front();
    checks++;
    if (a_idv !== 1'b1 || a_id !== e.id) begin
      errors++;
      $display("FAIL mem_kept got id=%h want id=%h", a_id, e.id);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_fault();
    test_load();
    test_drain();
    test_back_to_back();
    test_restart();
    test_overflow();
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left qa=%0d qb=%0d want 0 0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
